barret_bist: RTL and testbench
==============================

Name: barret_bist

Overview:
- Hardware self-test driver and checker for the Barrett reducer family (e.g. barret_for_3923). It is the opposite end of the reducer's din_a/dout_r interface.
- Sweeps din_a over 0..sweep_last and compares each dout_r against a golden residue. The golden residue comes from a wrapping counter, so no divider is needed.
- Reports pass/fail, a saturating error count and the first failing input.
- Sits beside a reducer instance on silicon or FPGA, replacing the file-based simulation check.

Parameters:
- Q, 3923, modulus under test
- IN_W, 23, width of din_a
- OUT_W, 12, width of dout_r; must satisfy 2^OUT_W > Q-1
- DUT_LAT, 0, reducer latency in clocks; 0 means combinational; legal range 0..7
- ERR_W, 16, width of err_count

Ports:
- clk, in, 1, clock, rising edge
- rst_n, in, 1, asynchronous active-low reset
- start, in, 1, single-cycle pulse; sampled only in IDLE or DONE
- sweep_last, in, IN_W, last input value of the sweep; latched at start
- dut_din_a, out, IN_W, drives reducer din_a
- dut_dout_r, in, OUT_W, reducer dout_r
- busy, out, 1, high in RUN and DRAIN
- done, out, 1, high in DONE
- pass, out, 1, done and err_count==0
- err_count, out, ERR_W, mismatches; saturates at all-ones
- first_err_din, out, IN_W, din_a value of the first mismatch; valid when err_count!=0

Behaviour:
- Reset (async, rst_n=0):
  - State = IDLE.
  - dut_din_a=0, busy=0, done=0, pass=0, err_count=0, first_err_din=0.
  - Expected-residue register and compare pipeline cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start. DONE -> RUN on start (restart).
  - On entry to RUN: latch sweep_last; dut_din_a=0, expected=0, err_count=0, first_err_din=0.
  - RUN: one vector per cycle.
    - If dut_din_a != last: increment dut_din_a; increment expected, wrapping Q-1 -> 0.
    - If dut_din_a == last: no increment, so there is no overflow even when last = 2^IN_W-1. Go to DRAIN.
  - DRAIN: DUT_LAT+1 cycles until all in-flight comparisons have retired, then DONE.
  - DONE: hold all outputs until start or reset.
- start while busy is ignored.
- Comparison path:
  - A valid/expected shift pipeline of depth DUT_LAT aligns the golden residue and din_a with dut_dout_r.
  - dut_dout_r is sampled at the edge ending the DUT_LAT-th cycle after the vector was driven.
  - On a mismatch, err_count increments (saturating). first_err_din is captured only when err_count was 0.
- Timing (start-sampling edge = edge 0, L = sweep_last):
  - Vector k is driven after edge k+... specifically, vector k is driven during the cycle following edge k.
  - Its error update occurs at edge k+1+DUT_LAT.
  - done rises after edge L+DUT_LAT+2, with err_count already final.
- Boundaries:
  - L=0: exactly one vector.
  - Expected residue wraps at every multiple of Q.
  - dut_dout_r values >= Q always count as errors.
  - Reset mid-sweep aborts immediately to IDLE with cleared outputs.
  - Restart from DONE clears results in the same edge that enters RUN.
- The golden residue is exact by construction: an incrementing count mod Q. No multiplier is used.

Decomposition:
- Shared package barret_pkg:
  - FSM state enum (IDLE/RUN/DRAIN/DONE).
  - Default Q, IN_W, OUT_W constants for each supported prime, matching the reducer instances.
- One natural sub-module, mod_counter: a wrapping counter mod Q with enable, clear and wrap flag. It is reused for the golden residue.
- Compare-alignment pipeline stays inline.

Test Plan:
1. Correct behavioural reducer (dout = din mod 3923), DUT_LAT=0, sweep_last=3922 -> done after edge 3924; err_count=0; pass=1.
2. Faulty reducer returning din mod 3923 except when din=3923 or 7846 (returns 3923), sweep_last=8000 -> err_count=2; first_err_din=3923; pass=0.
3. Correct reducer, DUT_LAT=2, sweep_last=0 -> single vector; done after edge 4; err_count=0. Also pulse start while busy in a longer run -> no effect.
4. Stuck-at-0 reducer, ERR_W=4, sweep_last=100 -> err_count saturates at 15 (100 true errors, din=0 passes); first_err_din=1.
5. Assert rst_n low at cycle 50 of a sweep with sweep_last=3922 -> outputs immediately zero; state IDLE. A subsequent start runs a clean full pass=1 sweep.
6. Restart: after scenario 2 completes, start with a correct reducer -> err_count and first_err_din cleared at RUN entry; ends with pass=1.

Source files
------------

// File: rtl/barret_pkg.sv
// rtl/barret_pkg.sv - shared types and per-prime defaults for the Barrett reducer family
package barret_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    // Defaults matching the reducer instances: modulus, input width, residue width
    localparam int Q_3923      = 3923;
    localparam int IN_W_3923   = 23;
    localparam int OUT_W_3923  = 12;

    localparam int Q_7681      = 7681;
    localparam int IN_W_7681   = 26;
    localparam int OUT_W_7681  = 13;

    localparam int Q_12289     = 12289;
    localparam int IN_W_12289  = 28;
    localparam int OUT_W_12289 = 14;

    // Deepest reducer pipeline the drain counter can cover
    localparam int DUT_LAT_MAX = 7;

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - wrapping counter modulo Q with enable, clear and wrap flag
module mod_counter #(
    parameter int Q = 3923,
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         wrap
);

    // Wrap flag marks the last residue before returning to zero
    assign wrap = (count == W'(Q - 1));

    // Count 0..Q-1; clear has priority over enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/barret_bist.sv
// rtl/barret_bist.sv - self-test sweep driver and residue checker for a Barrett reducer
module barret_bist
    import barret_pkg::*;
#(
    parameter int Q       = Q_3923,
    parameter int IN_W    = IN_W_3923,
    parameter int OUT_W   = OUT_W_3923,
    parameter int DUT_LAT = 0,
    parameter int ERR_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [IN_W-1:0]  sweep_last,
    output logic [IN_W-1:0]  dut_din_a,
    input  logic [OUT_W-1:0] dut_dout_r,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IN_W-1:0]  first_err_din
);

    bist_state_e      state;
    bist_state_e      state_nxt;
    logic [IN_W-1:0]  last_q;
    logic             start_ok;
    logic             in_run;
    logic             at_last;
    logic             step;
    logic [OUT_W-1:0] exp_r;
    logic             exp_wrap;
    logic [2:0]       drain_cnt;
    logic             drain_end;
    logic             cmp_vld;
    logic [OUT_W-1:0] cmp_exp;
    logic [IN_W-1:0]  cmp_din;
    logic             mismatch;

    // start is honoured only when no sweep is in flight
    assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE));
    assign in_run    = (state == ST_RUN);
    assign at_last   = (dut_din_a == last_q);
    // The last vector is held rather than incremented, so an all-ones last never overflows
    assign step      = in_run && !at_last;
    assign drain_end = (drain_cnt == 3'(DUT_LAT));

    assign busy = (state == ST_RUN) || (state == ST_DRAIN);
    assign done = (state == ST_DONE);
    assign pass = done && (err_count == '0);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start)     state_nxt = ST_RUN;
            ST_RUN:   if (at_last)   state_nxt = ST_DRAIN;
            ST_DRAIN: if (drain_end) state_nxt = ST_DONE;
            ST_DONE:  if (start)     state_nxt = ST_RUN;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    // Latch the sweep end point when a sweep begins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= '0;
        end else if (start_ok) begin
            last_q <= sweep_last;
        end
    end

    // Stimulus counter driving the reducer input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dut_din_a <= '0;
        end else if (start_ok) begin
            dut_din_a <= '0;
        end else if (step) begin
            dut_din_a <= dut_din_a + IN_W'(1);
        end
    end

    // Golden residue advances in lockstep with the stimulus, so it always equals din mod Q
    mod_counter #(
        .Q (Q),
        .W (OUT_W)
    ) u_exp_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (step),
        .clr   (start_ok),
        .count (exp_r),
        .wrap  (exp_wrap)
    );

    // Drain timer: counts 0..DUT_LAT while the last comparisons retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drain_cnt <= '0;
        end else if (state != ST_DRAIN) begin
            drain_cnt <= '0;
        end else begin
            drain_cnt <= drain_cnt + 3'd1;
        end
    end

    // Alignment of (valid, expected, din) with the reducer output
    generate
        if (DUT_LAT == 0) begin : g_comb
            assign cmp_vld = in_run;
            assign cmp_exp = exp_r;
            assign cmp_din = dut_din_a;
        end else begin : g_pipe
            logic             sr_vld [DUT_LAT];
            logic [OUT_W-1:0] sr_exp [DUT_LAT];
            logic [IN_W-1:0]  sr_din [DUT_LAT];

            // Shift each driven vector's tag alongside the reducer's own pipeline
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DUT_LAT; i++) begin
                        sr_vld[i] <= 1'b0;
                        sr_exp[i] <= '0;
                        sr_din[i] <= '0;
                    end
                end else begin
                    sr_vld[0] <= in_run;
                    sr_exp[0] <= exp_r;
                    sr_din[0] <= dut_din_a;
                    for (int i = 1; i < DUT_LAT; i++) begin
                        sr_vld[i] <= sr_vld[i-1];
                        sr_exp[i] <= sr_exp[i-1];
                        sr_din[i] <= sr_din[i-1];
                    end
                end
            end

            assign cmp_vld = sr_vld[DUT_LAT-1];
            assign cmp_exp = sr_exp[DUT_LAT-1];
            assign cmp_din = sr_din[DUT_LAT-1];
        end
    endgenerate

    // Any reducer output >= Q differs from the golden value, so it is caught here too
    assign mismatch = cmp_vld && (dut_dout_r != cmp_exp);

    // Error accounting: saturating count and first failing input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count     <= '0;
            first_err_din <= '0;
        end else if (start_ok) begin
            err_count     <= '0;
            first_err_din <= '0;
        end else if (mismatch) begin
            if (err_count != {ERR_W{1'b1}}) begin
                err_count <= err_count + ERR_W'(1);
            end
            if (err_count == '0) begin
                first_err_din <= cmp_din;
            end
        end
    end

endmodule

// File: tb/tb_barret_bist.sv
// tb/tb_barret_bist.sv - directed table-driven bench for barret_bist
module tb_barret_bist;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reducer fault models: 0 exact, 1 wrong at 3923/7846, 2 stuck at zero
    function automatic logic [11:0] red(input logic [22:0] d, input int m);
        int r;
        r = int'(d) % 3923;
        if (m == 2) return 12'd0;
        if (m == 1 && (d == 23'd3923 || d == 23'd7846)) return 12'd3923;
        return 12'(r);
    endfunction

    // Instance 0: combinational reducer, 16-bit error count
    logic        start0;
    logic [22:0] last0, din0, first0;
    logic [11:0] dout0;
    logic        busy0, done0, pass0;
    logic [15:0] err0;
    int          mode0;
    assign dout0 = red(din0, mode0);

    barret_bist #(.Q(3923), .IN_W(23), .OUT_W(12), .DUT_LAT(0), .ERR_W(16)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .sweep_last(last0),
        .dut_din_a(din0), .dut_dout_r(dout0), .busy(busy0), .done(done0),
        .pass(pass0), .err_count(err0), .first_err_din(first0)
    );

    // Instance 2: two-cycle reducer pipeline
    logic        start2;
    logic [22:0] last2, din2, first2;
    logic [11:0] dout2, p2a, p2b;
    logic        busy2, done2, pass2;
    logic [15:0] err2;
    int          mode2;
    initial begin p2a = 12'd0; p2b = 12'd0; end
    always @(posedge clk) begin
        p2a <= red(din2, mode2);
        p2b <= p2a;
    end
    assign dout2 = p2b;

    barret_bist #(.Q(3923), .IN_W(23), .OUT_W(12), .DUT_LAT(2), .ERR_W(16)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sweep_last(last2),
        .dut_din_a(din2), .dut_dout_r(dout2), .busy(busy2), .done(done2),
        .pass(pass2), .err_count(err2), .first_err_din(first2)
    );

    // Instance 4: combinational reducer, 4-bit saturating error count
    logic        start4;
    logic [22:0] last4, din4, first4;
    logic [11:0] dout4;
    logic        busy4, done4, pass4;
    logic [3:0]  err4;
    int          mode4;
    assign dout4 = red(din4, mode4);

    barret_bist #(.Q(3923), .IN_W(23), .OUT_W(12), .DUT_LAT(0), .ERR_W(4)) u4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .sweep_last(last4),
        .dut_din_a(din4), .dut_dout_r(dout4), .busy(busy4), .done(done4),
        .pass(pass4), .err_count(err4), .first_err_din(first4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic logic get_done(input int w);
        case (w)
            0:       return done0;
            2:       return done2;
            default: return done4;
        endcase
    endfunction

    function automatic logic [31:0] get_err(input int w);
        case (w)
            0:       return 32'(err0);
            2:       return 32'(err2);
            default: return 32'(err4);
        endcase
    endfunction

    function automatic logic [31:0] get_first(input int w);
        case (w)
            0:       return 32'(first0);
            2:       return 32'(first2);
            default: return 32'(first4);
        endcase
    endfunction

    function automatic logic get_pass(input int w);
        case (w)
            0:       return pass0;
            2:       return pass2;
            default: return pass4;
        endcase
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0:       return busy0;
            2:       return busy2;
            default: return busy4;
        endcase
    endfunction

    task automatic set_start(input int w, input logic v, input int last);
        case (w)
            0:       begin start0 = v; last0 = 23'(last); end
            2:       begin start2 = v; last2 = 23'(last); end
            default: begin start4 = v; last4 = 23'(last); end
        endcase
    endtask

    // Full sweep on one instance; edges counted from the start-sampling edge
    task automatic sweep(input int w, input int last, input int lat,
                         input int exp_err, input int exp_first, input int exp_pass);
        int edges;
        @(negedge clk);
        set_start(w, 1'b1, last);
        @(posedge clk);
        #1;
        set_start(w, 1'b0, last);
        chk("entry_err", get_err(w), 0);
        chk("entry_first", get_first(w), 0);
        chk("entry_busy", 32'(get_busy(w)), 1);
        edges = 0;
        while (!get_done(w) && edges < 20000) begin
            @(posedge clk);
            edges++;
            #1;
        end
        chk("done_edge", edges, last + lat + 2);
        chk("err_count", get_err(w), exp_err);
        chk("first_err_din", get_first(w), exp_first);
        chk("pass", 32'(get_pass(w)), exp_pass);
        chk("busy_after", 32'(get_busy(w)), 0);
    endtask

    typedef struct {
        int mode;
        int last;
        int exp_err;
        int exp_first;
        int exp_pass;
    } vec_t;

    vec_t tbl [7];

    initial begin
        tbl[0] = '{0, 3922, 0, 0,    1};
        tbl[1] = '{1, 8000, 2, 3923, 0};
        tbl[2] = '{0, 3922, 0, 0,    1};
        tbl[3] = '{0, 0,    0, 0,    1};
        tbl[4] = '{1, 3923, 1, 3923, 0};
        tbl[5] = '{2, 5,    5, 1,    0};
        tbl[6] = '{0, 4000, 0, 0,    1};

        rst_n  = 1'b0;
        start0 = 1'b0; start2 = 1'b0; start4 = 1'b0;
        last0  = '0;   last2  = '0;   last4  = '0;
        mode0  = 0;    mode2  = 0;    mode4  = 2;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_din", 32'(din0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_pass", 32'(pass0), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_first", 32'(first0), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table of full sweeps on the combinational instance (restarts from DONE)
        for (int i = 0; i < 7; i++) begin
            mode0 = tbl[i].mode;
            sweep(0, tbl[i].last, 0, tbl[i].exp_err, tbl[i].exp_first, tbl[i].exp_pass);
        end

        // Latency-2 instance: single vector, then stuck-at-zero short sweep
        mode2 = 0;
        sweep(2, 0, 2, 0, 0, 1);
        mode2 = 2;
        sweep(2, 3, 2, 3, 1, 0);

        // Latency-2 instance: start pulses while busy must not disturb the sweep
        begin
            int edges;
            mode2 = 0;
            @(negedge clk);
            start2 = 1'b1; last2 = 23'd20;
            @(posedge clk);
            #1;
            start2 = 1'b0; last2 = 23'd5;
            edges = 0;
            while (!done2 && edges < 200) begin
                @(posedge clk);
                edges++;
                #1;
                start2 = (edges == 3 || edges == 10);
            end
            start2 = 1'b0;
            chk("busy_start_done_edge", edges, 24);
            chk("busy_start_err", 32'(err2), 0);
            chk("busy_start_pass", 32'(pass2), 1);
        end

        // Saturation of a 4-bit error count
        sweep(4, 100, 0, 15, 1, 0);

        // Reset mid-sweep, then a clean full sweep
        begin
            mode0 = 2;
            @(negedge clk);
            start0 = 1'b1; last0 = 23'd3922;
            @(posedge clk);
            #1;
            start0 = 1'b0;
            repeat (50) @(posedge clk);
            #1;
            chk("mid_err", 32'(err0), 49);
            chk("mid_din", 32'(din0), 50);
            chk("mid_first", 32'(first0), 1);
            @(negedge clk);
            rst_n = 1'b0;
            #1;
            chk("abort_din", 32'(din0), 0);
            chk("abort_busy", 32'(busy0), 0);
            chk("abort_done", 32'(done0), 0);
            chk("abort_err", 32'(err0), 0);
            chk("abort_first", 32'(first0), 0);
            @(negedge clk);
            rst_n = 1'b1;
            mode0 = 0;
            sweep(0, 3922, 0, 0, 0, 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
